// File: rtl/mcpu_alu_arbiter.sv
// Round-robin share of one combinational MCPU_Alu between ch0/ch1; result returned on owner's resp_valid.
// Latency: req_ready cycle, then EXEC, then resp_valid held until resp_ready[owner]; 3 cycles min per op.
// MCPU_ALU_ARB_STATS_EN adds saturating per-channel grant counters with a synchronous stats_clr.
module mcpu_alu_arbiter #(
  parameter int CMD_SIZE  = 2,
  parameter int WORD_SIZE = 8
`ifdef MCPU_ALU_ARB_STATS_EN
  ,
  parameter int CNT_SIZE  = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [CMD_SIZE-1:0]    req0_opcode,
  input  logic [WORD_SIZE-1:0]   req0_r1,
  input  logic [WORD_SIZE-1:0]   req0_r2,
  input  logic [CMD_SIZE-1:0]    req1_opcode,
  input  logic [WORD_SIZE-1:0]   req1_r1,
  input  logic [WORD_SIZE-1:0]   req1_r2,
  output logic [1:0]             resp_valid,
  input  logic [1:0]             resp_ready,
  output logic [2*WORD_SIZE-1:0] resp_out,
  output logic                   resp_overflow,
  output logic [CMD_SIZE-1:0]    alu_opcode,
  output logic [WORD_SIZE-1:0]   alu_r1,
  output logic [WORD_SIZE-1:0]   alu_r2,
  input  logic [2*WORD_SIZE-1:0] alu_out,
  input  logic                   alu_overflow,
`ifdef MCPU_ALU_ARB_STATS_EN
  input  logic                   stats_clr,
  output logic [CNT_SIZE-1:0]    grant_cnt0,
  output logic [CNT_SIZE-1:0]    grant_cnt1,
`endif
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   rr_ptr;
  logic   owner;
  logic   win;
  logic   accept;
  logic   resp_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // rr_ptr only matters when both channels are valid; a lone requester always wins.
  always_comb begin
    win       = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
    accept    = rst_n && (state == IDLE) && (req_valid != 2'b00);
    req_ready = 2'b00;
    if (accept) begin
      req_ready = win ? 2'b10 : 2'b01;
    end
    resp_hs   = (state == RESP) && resp_ready[owner];
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= 1'b0;
      owner         <= 1'b0;
      alu_opcode    <= '0;
      alu_r1        <= '0;
      alu_r2        <= '0;
      resp_out      <= '0;
      resp_overflow <= 1'b0;
      resp_valid    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= win;
            alu_opcode <= win ? req1_opcode : req0_opcode;
            alu_r1     <= win ? req1_r1     : req0_r1;
            alu_r2     <= win ? req1_r2     : req0_r2;
          end
        end
        EXEC: begin
          resp_out      <= alu_out;
          resp_overflow <= alu_overflow;
          resp_valid    <= owner ? 2'b10 : 2'b01;
        end
        RESP: begin
          // Hand preference to the other channel so simultaneous requesters alternate.
          if (resp_hs) begin
            resp_valid <= 2'b00;
            rr_ptr     <= ~owner;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MCPU_ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (stats_clr) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req_ready[0] && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req_ready[1] && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mcpu_alu_arbiter.sv
// Scoreboard bench for mcpu_alu_arbiter: predictor pushes expected results, monitor pops on handshake.
// Stats checks are compiled only with MCPU_ALU_ARB_STATS_EN.
module tb_mcpu_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [1:0]  req0_opcode = 2'd0, req1_opcode = 2'd0;
  logic [7:0]  req0_r1 = 8'd0, req0_r2 = 8'd0, req1_r1 = 8'd0, req1_r2 = 8'd0;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready = 2'b00;
  logic [15:0] resp_out;
  logic        resp_overflow;
  logic [1:0]  alu_opcode;
  logic [7:0]  alu_r1, alu_r2;
  logic [15:0] alu_out;
  logic        alu_overflow;
  logic        busy;
`ifdef MCPU_ALU_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  mcpu_alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_opcode(req0_opcode), .req0_r1(req0_r1), .req0_r2(req0_r2),
    .req1_opcode(req1_opcode), .req1_r1(req1_r1), .req1_r2(req1_r2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_out(resp_out), .resp_overflow(resp_overflow),
    .alu_opcode(alu_opcode), .alu_r1(alu_r1), .alu_r2(alu_r2),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
`ifdef MCPU_ALU_ARB_STATS_EN
    .stats_clr(stats_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
    .busy(busy)
  );

  // Stand-in for the shared combinational ALU.
  always_comb begin
    {alu_overflow, alu_out} = 17'd0;
    case (alu_opcode)
      2'd0:    {alu_overflow, alu_out} = {9'd0, alu_r1 & alu_r2};
      2'd1:    {alu_overflow, alu_out} = {9'd0, alu_r1 | alu_r2};
      2'd2:    {alu_overflow, alu_out} = {9'd0, alu_r1 ^ alu_r2};
      default: {alu_overflow, alu_out} = {9'd0, alu_r1} + {9'd0, alu_r2};
    endcase
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  function automatic logic [16:0] ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    return {9'd0, a & b};
      2'd1:    return {9'd0, a | b};
      2'd2:    return {9'd0, a ^ b};
      default: return 17'(int'(a) + int'(b));
    endcase
  endfunction

  typedef struct {
    logic        ch;
    logic [16:0] res;
  } exp_t;

  exp_t sbq[$];
  logic pref = 1'b0;

  // Reference model: one call per idle cycle; consumes the whole op while one is in flight.
  task automatic model_step();
    logic        w;
    logic [1:0]  oh;
    logic [16:0] r;
    int          guard;
    if (!rst_n) begin pref = 1'b0; sbq.delete(); return; end
    chk("idle_busy", busy, 0);
    if (req_valid == 2'b00) begin
      chk("idle_rdy", req_ready, 0);
      return;
    end
    w  = (req_valid == 2'b11) ? pref : req_valid[1];
    oh = w ? 2'b10 : 2'b01;
    chk("grant", req_ready, oh);
    r  = w ? ref_alu(req1_opcode, req1_r1, req1_r2) : ref_alu(req0_opcode, req0_r1, req0_r2);
    sbq.push_back('{w, r});
    @(negedge clk);
    if (!rst_n) begin pref = 1'b0; sbq.delete(); return; end
    chk("exec_busy", busy, 1);
    chk("exec_rdy", req_ready, 0);
    chk("exec_vld", resp_valid, 0);
    @(negedge clk);
    if (!rst_n) begin pref = 1'b0; sbq.delete(); return; end
    chk("lat_vld", resp_valid, oh);
    chk("lat_dat", {resp_overflow, resp_out}, r);
    guard = 0;
    while (!resp_ready[w]) begin
      @(negedge clk);
      if (!rst_n) begin pref = 1'b0; sbq.delete(); return; end
      chk("hold_vld", resp_valid, oh);
      chk("hold_dat", {resp_overflow, resp_out}, r);
      chk("hold_rdy", req_ready, 0);
      chk("hold_busy", busy, 1);
      guard++;
      if (guard > 100) begin fail_now("resp_timeout"); return; end
    end
    pref = ~w;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  // Monitor: pops the scoreboard on every completed response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ((resp_valid & resp_ready) != 2'b00)) begin
      if (sbq.size() == 0) begin
        fail_now("unexpected_resp");
      end else begin
        e = sbq.pop_front();
        chk("mon_ch", resp_valid, e.ch ? 2'b10 : 2'b01);
        chk("mon_dat", {resp_overflow, resp_out}, e.res);
      end
    end
  end

`ifdef MCPU_ALU_ARB_STATS_EN
  int m0 = 0, m1 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin m0 = 0; m1 = 0; end
    chk("cnt0", grant_cnt0, m0);
    chk("cnt1", grant_cnt1, m1);
    if (!rst_n || stats_clr) begin
      m0 = 0; m1 = 0;
    end else begin
      if (req_valid[0] && req_ready[0] && m0 < 65535) m0++;
      if (req_valid[1] && req_ready[1] && m1 < 65535) m1++;
    end
  end
`endif

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_out"}, resp_out, 0);
    chk({tag, "_resp_ovf"}, resp_overflow, 0);
    chk({tag, "_alu_op"}, alu_opcode, 0);
    chk({tag, "_alu_r1"}, alu_r1, 0);
    chk({tag, "_alu_r2"}, alu_r2, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Present one request, wait for its grant, then drop valid and disturb r1 (5 -> 9 for 5).
  task automatic issue(input logic ch, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int guard;
    @(posedge clk); #1;
    if (ch) begin req1_opcode = op; req1_r1 = a; req1_r2 = b; end
    else    begin req0_opcode = op; req0_r1 = a; req0_r2 = b; end
    req_valid[ch] = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!req_ready[ch] && guard < 60);
    if (!req_ready[ch]) fail_now("grant_timeout");
    @(posedge clk); #1;
    req_valid[ch] = 1'b0;
    if (ch) req1_r1 = a ^ 8'h0C;
    else    req0_r1 = a ^ 8'h0C;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset("rst0");
    @(posedge clk); #1;
    rst_n = 1'b1;
    resp_ready = 2'b11;

    // ch0 ADD 200+100 = 300
    issue(1'b0, 2'd3, 8'd200, 8'd100);
    idle_cycles(4);
    issue(1'b1, 2'd1, 8'h0F, 8'hF0);
    idle_cycles(4);

    // Both valid continuously: AND 3&2 on ch0, XOR 3^2 on ch1
    req0_opcode = 2'd0; req0_r1 = 8'd3; req0_r2 = 8'd2;
    req1_opcode = 2'd2; req1_r1 = 8'd3; req1_r2 = 8'd2;
    req_valid = 2'b11;
    idle_cycles(9);
    req_valid = 2'b00;
    idle_cycles(4);

    // Backpressure: only the non-owner is ready for a while
    resp_ready = 2'b10;
    issue(1'b0, 2'd3, 8'd255, 8'd255);
    idle_cycles(6);
    resp_ready = 2'b11;
    idle_cycles(4);

    // Operand change after accept: result must use 5
    issue(1'b0, 2'd3, 8'd5, 8'd2);
    idle_cycles(4);

    // Reset during EXEC with rr_ptr pointing at ch1
    issue(1'b0, 2'd1, 8'd1, 8'd2);
    idle_cycles(4);
    issue(1'b1, 2'd2, 8'hAA, 8'h55);
    rst_n = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    check_reset("rst_exec");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_grant_ch0", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    idle_cycles(4);

    // Reset during RESP
    resp_ready = 2'b00;
    issue(1'b0, 2'd3, 8'd77, 8'd88);
    idle_cycles(2);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("rst_resp");
    @(posedge clk); #1;
    rst_n = 1'b1;
    resp_ready = 2'b11;
    idle_cycles(2);

    // Randomized traffic and backpressure
    for (int i = 0; i < 400; i++) begin
      req_valid   = 2'($urandom);
      req0_opcode = 2'($urandom);
      req1_opcode = 2'($urandom);
      req0_r1     = 8'($urandom);
      req0_r2     = 8'($urandom);
      req1_r1     = 8'($urandom);
      req1_r2     = 8'($urandom);
      resp_ready  = 2'($urandom);
      idle_cycles(1);
    end
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    idle_cycles(6);

`ifdef MCPU_ALU_ARB_STATS_EN
    stats_clr = 1'b1;
    idle_cycles(1);
    stats_clr = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0, 2'd3, 8'(i), 8'd1);
    for (int i = 0; i < 3; i++) issue(1'b1, 2'd0, 8'(i), 8'd7);
    idle_cycles(4);
    @(negedge clk);
    chk("stats_cnt0_4", grant_cnt0, 4);
    chk("stats_cnt1_3", grant_cnt1, 3);
    @(posedge clk); #1;
    stats_clr = 1'b1;
    issue(1'b0, 2'd1, 8'd3, 8'd4);
    stats_clr = 1'b0;
    @(negedge clk);
    chk("stats_clr_cnt0", grant_cnt0, 0);
    chk("stats_clr_cnt1", grant_cnt1, 0);
    idle_cycles(4);
`endif

    chk("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule
